// File: rtl/display_source_ctrl.sv
// Chooses what the four-digit score display shows: attract rotation, live play
// values, or a blinking message that preempts both for a fixed time.
module display_source_ctrl #(
  parameter int CLK_FREQ  = 50_000,
  parameter int ROTATE_MS = 2000,
  parameter int MSG_MS    = 1500,
  parameter int BLINK_MS  = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_active,
  input  logic [15:0] score_bcd,
  input  logic [15:0] hiscore_bcd,
  input  logic [7:0]  time_bcd,
  input  logic        msg_valid,
  input  logic [15:0] msg_bcd,
  output logic        msg_ready,
  output logic [15:0] bcd_value,
  output logic [1:0]  src
);

  localparam int MS_CNT = CLK_FREQ / 1000;
  localparam int MS_MAX = (ROTATE_MS > MSG_MS) ? ROTATE_MS : MSG_MS;
  localparam int PW     = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;
  localparam int MW     = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int BW     = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(MS_CNT - 1);
  localparam logic [MW-1:0] ROT_LAST   = MW'(ROTATE_MS - 1);
  localparam logic [MW-1:0] MSG_LAST   = MW'(MSG_MS - 1);
  localparam logic [MW-1:0] MS_LAST    = MW'(MS_MAX - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  typedef enum logic [1:0] {
    ST_HI    = 2'd0,
    ST_SCORE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_MSG   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [MW-1:0]   ms_q, ms_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic [15:0]     msg_q, msg_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [1:0]      src_q, src_d;
  logic            tick, accept, restart;

  assign msg_ready = (state_q != ST_MSG);
  assign bcd_value = bcd_q;
  assign src       = src_q;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    accept  = msg_valid && msg_ready;
    state_d = state_q;
    msg_d   = msg_q;

    // Accept beats game_active, which beats rotate expiry.
    case (state_q)
      ST_HI: begin
        if (accept)                       state_d = ST_MSG;
        else if (game_active)             state_d = ST_PLAY;
        else if (tick && ms_q == ROT_LAST) state_d = ST_SCORE;
      end
      ST_SCORE: begin
        if (accept)                       state_d = ST_MSG;
        else if (game_active)             state_d = ST_PLAY;
        else if (tick && ms_q == ROT_LAST) state_d = ST_HI;
      end
      ST_PLAY: begin
        if (accept)            state_d = ST_MSG;
        else if (!game_active) state_d = ST_SCORE;
      end
      ST_MSG: begin
        if (tick && ms_q == MSG_LAST) state_d = game_active ? ST_PLAY : ST_HI;
      end
      default: state_d = ST_HI;
    endcase

    if (accept) msg_d = msg_bcd;

    // Timebase restarts on every entry so each dwell is exactly D ms long.
    restart = accept || (state_d != state_q);

    presc_d = (restart || tick) ? '0 : presc_q + PW'(1);

    ms_d = ms_q;
    if (restart)                     ms_d = '0;
    else if (tick && ms_q != MS_LAST) ms_d = ms_q + MW'(1);

    blink_cnt_d = blink_cnt_q;
    if (restart)    blink_cnt_d = '0;
    else if (tick)  blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);

    blink_d = blink_q;
    if (restart || state_q != ST_MSG)           blink_d = 1'b1;
    else if (tick && blink_cnt_q == BLINK_LAST) blink_d = ~blink_q;

    case (state_q)
      ST_HI:    bcd_d = hiscore_bcd;
      ST_SCORE: bcd_d = score_bcd;
      ST_PLAY:  bcd_d = {time_bcd, score_bcd[7:0]};
      ST_MSG:   bcd_d = blink_q ? msg_q : 16'hFFFF;
      default:  bcd_d = 16'hFFFF;
    endcase

    src_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HI;
      presc_q     <= '0;
      ms_q        <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      msg_q       <= 16'hFFFF;
      bcd_q       <= 16'hFFFF;
      src_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      msg_q       <= msg_d;
      bcd_q       <= bcd_d;
      src_q       <= src_d;
    end
  end

endmodule

// File: tb/tb_display_source_ctrl.sv
// Bench for display_source_ctrl: directed scenarios plus random traffic, all
// checked against a cycle-count model of the display sequencing rules.
module tb_display_source_ctrl;

  localparam int MSC  = 50;
  localparam int ROT  = 4;
  localparam int MSGD = 6;
  localparam int BLK  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_active;
  logic [15:0] score_bcd, hiscore_bcd, msg_bcd;
  logic [7:0]  time_bcd;
  logic        msg_valid;
  logic        msg_ready;
  logic [15:0] bcd_value;
  logic [1:0]  src;

  int checks = 0;
  int errors = 0;

  // Model: state number, edges spent in it since entry, latched message.
  int          m_state, m_cyc;
  logic [15:0] m_msg;
  bit          m_acc;
  logic [15:0] exp_bcd;
  logic [1:0]  exp_src;
  logic        exp_ready;

  display_source_ctrl #(
    .CLK_FREQ(50_000), .ROTATE_MS(ROT), .MSG_MS(MSGD), .BLINK_MS(BLK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_active(game_active),
    .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd), .time_bcd(time_bcd),
    .msg_valid(msg_valid), .msg_bcd(msg_bcd), .msg_ready(msg_ready),
    .bcd_value(bcd_value), .src(src)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic model_edge();
    int nxt;
    m_acc = 0;
    if (!rst_n) begin
      m_state = 0; m_cyc = 0; m_msg = 16'hFFFF; exp_bcd = 16'hFFFF;
    end else begin
      case (m_state)
        0:       exp_bcd = hiscore_bcd;
        1:       exp_bcd = score_bcd;
        2:       exp_bcd = {time_bcd, score_bcd[7:0]};
        default: exp_bcd = (((m_cyc / (BLK * MSC)) % 2) == 0) ? m_msg : 16'hFFFF;
      endcase
      nxt = m_state;
      if (msg_valid && m_state != 3) begin
        nxt = 3; m_msg = msg_bcd; m_acc = 1;
      end else if (m_state == 3) begin
        if (m_cyc == MSGD * MSC - 1) nxt = game_active ? 2 : 0;
      end else if (m_state == 2) begin
        if (!game_active) nxt = 1;
      end else if (game_active) begin
        nxt = 2;
      end else if (m_cyc == ROT * MSC - 1) begin
        nxt = (m_state == 0) ? 1 : 0;
      end
      m_cyc   = (nxt != m_state || m_acc) ? 0 : m_cyc + 1;
      m_state = nxt;
    end
    exp_src   = 2'(m_state);
    exp_ready = (m_state != 3);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; game_active = 1'b0; msg_valid = 1'b0; msg_bcd = 16'h0000;
    hiscore_bcd = 16'h0120; score_bcd = 16'h0045; time_bcd = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({bcd_value, src, msg_ready} !== {16'hFFFF, 2'd0, 1'b1})
        $display("FAIL reset_vals got bcd=%h src=%0d rdy=%b want bcd=ffff src=0 rdy=1",
                 bcd_value, src, msg_ready);
        if ({bcd_value, src, msg_ready} !== {16'hFFFF, 2'd0, 1'b1}) errors++;
    end
    $display("scenario reset done");
  endtask

  task automatic test_rotation();
    logic [15:0] want;
    rst_n = 1'b1;
    for (int k = 1; k <= 401; k++) begin
      step();
      want = (k <= 200 || k == 401) ? 16'h0120 : 16'h0045;
      checks++;
      if (bcd_value !== want) begin
        errors++;
        $display("FAIL rotate_bcd cycle=%0d got %h want %h", k, bcd_value, want);
      end
      checks++;
      if ({src, msg_ready} !== {exp_src, exp_ready}) begin
        errors++;
        $display("FAIL rotate_src cycle=%0d got src=%0d rdy=%b want src=%0d rdy=%b",
                 k, src, msg_ready, exp_src, exp_ready);
      end
    end
    $display("scenario rotation done");
  endtask

  task automatic test_play();
    time_bcd = 8'h30; score_bcd = 16'h0007; game_active = 1'b1;
    step();
    checks++;
    if (src !== 2'd2) begin
      errors++; $display("FAIL play_src got %0d want 2", src);
    end
    step();
    checks++;
    if (bcd_value !== 16'h3007) begin
      errors++; $display("FAIL play_bcd got %h want 3007", bcd_value);
    end
    time_bcd = 8'h29;
    step();
    checks++;
    if (bcd_value !== 16'h2907) begin
      errors++; $display("FAIL play_time_upd got %h want 2907", bcd_value);
    end
    $display("scenario play done");
  endtask

  task automatic test_msg();
    logic [15:0] want;
    msg_valid = 1'b1; msg_bcd = 16'hF1FF;
    step();
    checks++;
    if ({src, msg_ready} !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL msg_accept got src=%0d rdy=%b want src=3 rdy=0", src, msg_ready);
    end
    msg_valid = 1'b0;
    for (int k = 1; k <= 301; k++) begin
      step();
      if (k <= 100 || (k > 200 && k <= 300)) want = 16'hF1FF;
      else if (k <= 200)                    want = 16'hFFFF;
      else                                  want = 16'h2907;
      checks++;
      if (bcd_value !== want) begin
        errors++; $display("FAIL msg_blink cycle=%0d got %h want %h", k, bcd_value, want);
      end
      checks++;
      if ({src, msg_ready} !== ((k < 300) ? {2'd3, 1'b0} : {2'd2, 1'b1})) begin
        errors++; $display("FAIL msg_state cycle=%0d got src=%0d rdy=%b", k, src, msg_ready);
      end
    end
    $display("scenario message done");
  endtask

  task automatic test_msg_stall();
    msg_valid = 1'b1; msg_bcd = 16'hF2FF;
    step();
    checks++;
    if (src !== 2'd3) begin
      errors++; $display("FAIL stall_first_accept got src=%0d want 3", src);
    end
    msg_bcd = 16'hFF3F; game_active = 1'b0;
    for (int k = 1; k <= 302; k++) begin
      step();
      checks++;
      if ({bcd_value, src, msg_ready} !== {exp_bcd, exp_src, exp_ready}) begin
        errors++;
        $display("FAIL stall_model cycle=%0d got %h/%0d/%b want %h/%0d/%b", k,
                 bcd_value, src, msg_ready, exp_bcd, exp_src, exp_ready);
      end
      if (k <= 100) begin
        checks++;
        if (bcd_value !== 16'hF2FF) begin
          errors++; $display("FAIL stall_latch cycle=%0d got %h want f2ff", k, bcd_value);
        end
      end
      if (k < 300) begin
        checks++;
        if ({src, msg_ready} !== {2'd3, 1'b0}) begin
          errors++; $display("FAIL stall_hold cycle=%0d got src=%0d rdy=%b", k, src, msg_ready);
        end
      end
      if (k == 300) begin
        checks++;
        if ({src, msg_ready} !== {2'd0, 1'b1}) begin
          errors++; $display("FAIL stall_exit_hi got src=%0d rdy=%b want 0/1", src, msg_ready);
        end
      end
      if (k == 301) begin
        checks++;
        if ({bcd_value, src} !== {16'h0120, 2'd3}) begin
          errors++; $display("FAIL stall_second_accept got bcd=%h src=%0d want 0120/3", bcd_value, src);
        end
        msg_valid = 1'b0;
      end
      if (k == 302) begin
        checks++;
        if (bcd_value !== 16'hFF3F) begin
          errors++; $display("FAIL stall_second_msg got %h want ff3f", bcd_value);
        end
      end
    end
    for (int k = 0; k < 300; k++) begin
      step();
      checks++;
      if ({bcd_value, src, msg_ready} !== {exp_bcd, exp_src, exp_ready}) begin
        errors++;
        $display("FAIL stall_tail cycle=%0d got %h/%0d/%b want %h/%0d/%b", k,
                 bcd_value, src, msg_ready, exp_bcd, exp_src, exp_ready);
      end
    end
    $display("scenario message stall done");
  endtask

  task automatic test_same_cycle();
    int guard = 0;
    while (exp_src != 2'd1 && guard < 1000) begin
      step();
      guard++;
      checks++;
      if ({bcd_value, src} !== {exp_bcd, exp_src}) begin
        errors++; $display("FAIL same_wait got %h/%0d want %h/%0d", bcd_value, src, exp_bcd, exp_src);
      end
    end
    checks++;
    if (src !== 2'd1) begin
      errors++; $display("FAIL same_reach_score got src=%0d want 1", src);
    end
    msg_valid = 1'b1; msg_bcd = 16'h0042; game_active = 1'b1;
    step();
    checks++;
    if (src !== 2'd3) begin
      errors++; $display("FAIL same_priority got src=%0d want 3", src);
    end
    msg_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      checks++;
      if ({bcd_value, src, msg_ready} !== {exp_bcd, exp_src, exp_ready}) begin
        errors++;
        $display("FAIL same_model cycle=%0d got %h/%0d/%b want %h/%0d/%b", k,
                 bcd_value, src, msg_ready, exp_bcd, exp_src, exp_ready);
      end
    end
    checks++;
    if (src !== 2'd2) begin
      errors++; $display("FAIL same_exit_play got src=%0d want 2", src);
    end
    $display("scenario same-cycle priority done");
  endtask

  task automatic test_reset_mid_msg();
    logic [15:0] want;
    msg_valid = 1'b1; msg_bcd = 16'h0099; game_active = 1'b0;
    step();
    msg_valid = 1'b0;
    for (int k = 1; k <= 150; k++) step();
    checks++;
    if (bcd_value !== 16'hFFFF || src !== 2'd3) begin
      errors++; $display("FAIL midmsg_off_phase got bcd=%h src=%0d want ffff/3", bcd_value, src);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({bcd_value, src, msg_ready} !== {16'hFFFF, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL midmsg_reset got bcd=%h src=%0d rdy=%b want ffff/0/1", bcd_value, src, msg_ready);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 401; k++) begin
      step();
      want = (k <= 200 || k == 401) ? 16'h0120 : 16'h0007;
      checks++;
      if (bcd_value !== want) begin
        errors++; $display("FAIL midmsg_rotate cycle=%0d got %h want %h", k, bcd_value, want);
      end
    end
    $display("scenario reset mid-message done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 4) == 0)   score_bcd   = 16'($urandom);
      if (($urandom % 8) == 0)   hiscore_bcd = 16'($urandom);
      if (($urandom % 4) == 0)   time_bcd    = 8'($urandom);
      if (($urandom % 250) == 0) game_active = ~game_active;
      if (!msg_valid && ($urandom % 300) == 0) begin
        msg_valid = 1'b1; msg_bcd = 16'($urandom);
      end
      rst_n = (($urandom % 1500) != 0);
      step();
      checks++;
      if ({bcd_value, src, msg_ready} !== {exp_bcd, exp_src, exp_ready}) begin
        errors++;
        $display("FAIL random cycle=%0d got %h/%0d/%b want %h/%0d/%b", i,
                 bcd_value, src, msg_ready, exp_bcd, exp_src, exp_ready);
      end
      if (m_acc) msg_valid = 1'b0;
    end
    rst_n = 1'b1;
    $display("scenario random done");
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_play();
    test_msg();
    test_msg_stall();
    test_same_cycle();
    test_reset_mid_msg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
